// File: rtl/pacote_rvsp.sv
// Shared definitions for the program loader and the instruction memory.
// The loader state encoding includes RX_CHK, which is only reachable with CARREGA_CHECKSUM_EN.
package pacote_rvsp;
    localparam int WORD_BYTES   = 4;
    localparam int INST_ENDER_W = 6;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        RX_CONT = 3'd1,
        RX_DADO = 3'd2,
        RX_CHK  = 3'd3,
        FIM     = 3'd4,
        ERRO    = 3'd5
    } estado_carga_t;
endpackage

// File: rtl/carrega_programa_monta_palavra.sv
// Assembles little-endian 32-bit words from a byte stream.
// Pulses palavra_pronta for one cycle, with the new word on palavra.
module monta_palavra
    import pacote_rvsp::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        limpa,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        ultimo_byte,
    output logic [31:0] palavra,
    output logic        palavra_pronta
);
    logic [1:0]  byte_idx;
    logic [23:0] lanes;

    assign ultimo_byte = (byte_idx == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx       <= 2'd0;
            lanes          <= 24'd0;
            palavra        <= 32'd0;
            palavra_pronta <= 1'b0;
        end else begin
            palavra_pronta <= 1'b0;
            if (limpa) begin
                byte_idx <= 2'd0;
            end else if (byte_en) begin
                // The last byte goes straight into the output word, so the
                // write is ready one cycle after the fourth transfer.
                if (ultimo_byte) begin
                    palavra        <= {byte_in, lanes};
                    palavra_pronta <= 1'b1;
                end else begin
                    lanes[{byte_idx, 3'b000} +: 8] <= byte_in;
                end
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end
endmodule

// File: rtl/carrega_programa.sv
// Program loader: framed byte stream -> instruction memory writes; holds the CPU halted.
// Optional trailing XOR checksum byte enabled by defining CARREGA_CHECKSUM_EN.
//
// state   | meaning
// OCIOSO  | after reset, waiting for inicia, CPU halted
// RX_CONT | receiving word count N
// RX_DADO | receiving 4*N data bytes, one memory write per word
// RX_CHK  | receiving checksum byte (CARREGA_CHECKSUM_EN only)
// FIM     | load done, CPU released
// ERRO    | load failed, CPU halted
module carrega_programa
    import pacote_rvsp::*;
#(
    parameter int ENDER_W = INST_ENDER_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicia,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               mem_we,
    output logic [ENDER_W-1:0] mem_ender,
    output logic [31:0]        mem_dado,
    output logic               cpu_halt,
    output logic               fim,
    output logic               erro
);
    localparam int         MAX_PAL   = 2 ** (ENDER_W - 2);
    localparam int         CNT_W     = ENDER_W - 1;
    localparam logic [8:0] MAX_PAL_B = 9'(MAX_PAL);

    estado_carga_t    estado, prox;
    logic [CNT_W-1:0] n_pal, cont_pal;
    logic             rx_ativo, inicia_ok, byte_dado, ultimo_byte, fim_dados, cont_invalido;
`ifdef CARREGA_CHECKSUM_EN
    logic [7:0]       chk;
`endif

    assign rx_ativo      = (estado == RX_CONT) || (estado == RX_DADO) || (estado == RX_CHK);
    assign byte_ready    = rx_ativo;
    assign fim           = (estado == FIM);
    assign erro          = (estado == ERRO);
    assign cpu_halt      = (estado != FIM);
    assign inicia_ok     = inicia && !rx_ativo;
    assign byte_dado     = byte_valid && (estado == RX_DADO);
    assign fim_dados     = byte_dado && ultimo_byte && (cont_pal == n_pal - CNT_W'(1));
    assign cont_invalido = (byte_in == 8'd0) || ({1'b0, byte_in} > MAX_PAL_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO, FIM, ERRO: if (inicia) prox = RX_CONT;
            RX_CONT:           if (byte_valid) prox = cont_invalido ? ERRO : RX_DADO;
`ifdef CARREGA_CHECKSUM_EN
            RX_DADO:           if (fim_dados) prox = RX_CHK;
            RX_CHK:            if (byte_valid) prox = (byte_in == chk) ? FIM : ERRO;
`else
            RX_DADO:           if (fim_dados) prox = FIM;
`endif
            default:           prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_pal     <= '0;
            cont_pal  <= '0;
            mem_ender <= '0;
`ifdef CARREGA_CHECKSUM_EN
            chk       <= 8'd0;
`endif
        end else begin
            if (inicia_ok) begin
                cont_pal <= '0;
`ifdef CARREGA_CHECKSUM_EN
                chk      <= 8'd0;
`endif
            end
            if (estado == RX_CONT && byte_valid && !cont_invalido)
                n_pal <= CNT_W'(byte_in);
            if (byte_dado) begin
`ifdef CARREGA_CHECKSUM_EN
                chk <= chk ^ byte_in;
`endif
                if (ultimo_byte) begin
                    mem_ender <= {cont_pal[ENDER_W-3:0], 2'b00};
                    cont_pal  <= cont_pal + CNT_W'(1);
                end
            end
        end
    end

    monta_palavra u_monta (
        .clk            (clk),
        .rst_n          (rst_n),
        .limpa          (inicia_ok),
        .byte_en        (byte_dado),
        .byte_in        (byte_in),
        .ultimo_byte    (ultimo_byte),
        .palavra        (mem_dado),
        .palavra_pronta (mem_we)
    );
endmodule

// File: doc/carrega_programa.md
Name: carrega_programa

Overview:
- Program loader that writes the instruction memory from a byte stream.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one write per word to the instruction memory write port.
- Holds the processor in halt (PC frozen) until the load completes cleanly.

Parameters:
ENDER_W, 6, byte-address width of instruction memory; capacity = 2^(ENDER_W-2) words (default 16)
MAX_PAL, 2^(ENDER_W-2), maximum accepted word count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
inicia  input  1  one-cycle pulse; starts a load when OCIOSO/FIM/ERRO
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte this cycle (transfer = valid & ready)
mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
mem_ender  output  ENDER_W  byte address of word written (word index << 2)
mem_dado  output  32  assembled instruction word
cpu_halt  output  1  high while loading; processor PC update inhibited
fim  output  1  load completed successfully (level, until next inicia)
erro  output  1  load failed (level, until next inicia)

Behaviour:
- Reset (async, rst_n=0): estado=OCIOSO; byte_ready=0, mem_we=0, mem_ender=0, mem_dado=0, cpu_halt=1, fim=0, erro=0; internal counters cleared.
  - Processor stays halted after reset until a successful load.
- States: OCIOSO, RX_CONT, RX_DADO, RX_CHK (CHECKSUM_EN only), FIM, ERRO.
- OCIOSO/FIM/ERRO + inicia:
  - Go to RX_CONT.
  - Clear fim, erro, byte index, word index and checksum.
  - Set cpu_halt=1.
- RX_CONT:
  - byte_ready=1.
  - On transfer, N=byte_in.
  - N=0 or N>MAX_PAL → ERRO.
  - Otherwise latch N and go to RX_DADO.
- RX_DADO:
  - byte_ready=1.
  - Each transfer shifts the byte into lane [8*k+7:8*k], k=byte index 0..3; first byte is the LSB.
  - checksum ^= byte_in.
  - On the k=3 transfer, the next cycle registers:
    - mem_we=1
    - mem_dado = the complete word
    - mem_ender = word index<<2
  - The word index then increments.
  - Write latency: exactly 1 cycle after the 4th byte transfer.
  - Streaming continues without stall; byte_ready stays 1 during the write cycle.
  - After word N-1 is assembled: go to RX_CHK (CHECKSUM_EN) or FIM.
  - The final mem_we pulse occurs in the first cycle of the next state.
- RX_CHK:
  - byte_ready=1.
  - On transfer, byte_in==checksum → FIM, otherwise ERRO.
  - Words already written remain in memory.
- FIM: fim=1, cpu_halt=0, byte_ready=0.
- ERRO: erro=1, cpu_halt=1, byte_ready=0.
- byte_valid without byte_ready: ignored, no state change. byte_valid=0 in any RX state: wait indefinitely.
- inicia during an RX state: ignored.
- inicia coincident with a transfer in FIM/ERRO: inicia wins; the byte is not consumed (byte_ready=0 that cycle).
- Reset mid-load: immediate abort to OCIOSO; a partially assembled word is discarded and no mem_we is issued; previously written words are not erased.
- fim and erro are never both 1.
- mem_ender wraps at 2^ENDER_W, which is unreachable given the N≤MAX_PAL check.

Optional Feature:
- CARREGA_CHECKSUM_EN defined: a trailing checksum byte (XOR of all 4N data bytes) is required after the data; a mismatch gives ERRO.
- Not defined: RX_CHK and the checksum register are absent, and the block enters FIM directly after the N-th word.

Decomposition:
- Shared package (pacote_rvsp):
  - state encoding typedef estado_carga_t.
  - Constants WORD_BYTES=4 and INST_ENDER_W=6, shared with the instruction memory.
- One natural sub-module: monta_palavra.
  - Byte-lane shift register plus 2-bit byte index.
  - Outputs the 32-bit word and a one-cycle palavra_pronta strobe.
- The FSM, word counter and checksum stay in the top.

Test Plan:
- Reset then inicia; send N=2, bytes 13 05 00 00 93 05 10 00 (checksum 0x90 with EN):
  - mem_we pulses with (ender 0x00, dado 0x00000513) and (0x04, 0x00100593).
  - Then fim=1, cpu_halt=0.
- N=0 and, separately, N=17 → erro=1, cpu_halt=1, mem_we never asserted.
- CARREGA_CHECKSUM_EN, N=1, bytes 01 02 03 04, checksum 0x05 → erro=1; word 0x04030201 still written at 0x00.
- Random byte_valid gaps (valid low 0-5 cycles) on an N=16 load → 16 writes, addresses 0x00..0x3C in order, data correct, fim=1.
- Assert rst_n=0 after 6 data bytes of an N=3 load → immediate OCIOSO; exactly one mem_we observed; all outputs at reset values.
- In FIM, pulse inicia together with byte_valid=1 → byte not consumed; state RX_CONT; fim=0, cpu_halt=1 next cycle.
